xpb_accum_ctrl: RTL

XPB_ACCUM_CTRL -- requirements
Module: xpb_accum_ctrl

---
 rtl/xpb_accum_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/xpb_accum_ctrl.sv
// xpb_accum_ctrl: sequences digit windows through the xpb tables and sums the looked-up entries.
// Optional zero-digit skipping is enabled by defining XPB_ACCUM_SKIP_ZERO_EN.
module xpb_accum_ctrl #(
    parameter int NUM_WINDOWS = 8,
    parameter int DIGIT_BITS  = 5,
    parameter int DATA_W      = 1024
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [NUM_WINDOWS*DIGIT_BITS-1:0]      digits_in,
    output logic [$clog2(NUM_WINDOWS)-1:0]         xpb_sel,
    output logic [DIGIT_BITS-1:0]                  xpb_digit,
    input  logic [DATA_W-1:0]                      xpb_data,
    output logic                                   busy,
    output logic                                   done,
    output logic [DATA_W+$clog2(NUM_WINDOWS)-1:0]  acc_out
);
    localparam int SEL_W = $clog2(NUM_WINDOWS);
    localparam int ACC_W = DATA_W + SEL_W;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                            state_q, state_d;
    logic [NUM_WINDOWS*DIGIT_BITS-1:0] digits_q, digits_d;
    logic [SEL_W-1:0]                  idx_q, idx_d;
    logic [ACC_W-1:0]                  acc_q, acc_d;

`ifdef XPB_ACCUM_SKIP_ZERO_EN
    // Returns {found, index} of the lowest nonzero window at or above lo.
    function automatic logic [SEL_W:0] find_nz(input logic [NUM_WINDOWS*DIGIT_BITS-1:0] d, input int lo);
        find_nz = '0;
        for (int w = NUM_WINDOWS - 1; w >= 0; w--)
            if (w >= lo && d[w*DIGIT_BITS +: DIGIT_BITS] != '0) find_nz = {1'b1, SEL_W'(w)};
    endfunction

    logic [SEL_W:0] first_nz, next_nz;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            digits_q <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
`ifdef XPB_ACCUM_SKIP_ZERO_EN
        first_nz = find_nz(digits_in, 0);
        next_nz  = find_nz(digits_q, int'(idx_q) + 1);
`endif
        case (state_q)
            IDLE: if (start) begin
                digits_d = digits_in;
                acc_d    = '0;
`ifdef XPB_ACCUM_SKIP_ZERO_EN
                idx_d    = first_nz[SEL_W-1:0];
                state_d  = first_nz[SEL_W] ? RUN : DONE;
`else
                idx_d    = '0;
                state_d  = RUN;
`endif
            end
            RUN: begin
                acc_d = acc_q + ACC_W'(xpb_data);
`ifdef XPB_ACCUM_SKIP_ZERO_EN
                if (next_nz[SEL_W]) idx_d = next_nz[SEL_W-1:0];
                else state_d = DONE;
`else
                if (idx_q == SEL_W'(NUM_WINDOWS - 1)) state_d = DONE;
                else idx_d = idx_q + SEL_W'(1);
`endif
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = state_q != IDLE;
        done      = state_q == DONE;
        xpb_sel   = state_q == RUN ? idx_q : '0;
        xpb_digit = state_q == RUN ? digits_q[int'(idx_q)*DIGIT_BITS +: DIGIT_BITS] : '0;
        acc_out   = acc_q;
    end
endmodule
